// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between a video prefetch FIFO and a CPU port.
// Grants are decided and issued in the same cycle; state holds the previous cycle's operation.
module fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              vid_pop,
    output logic [DATA_W-1:0] vid_pixel,
    output logic              vid_underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, VID, CPU_WR, CPU_RD} state_t;

    state_t            state, op, cop;
    logic              run, done;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     cnt, occ;
    logic [SW-1:0]     starve;
    logic              push, pop, in_ack, cpu_p, vid_ok, urg;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= op;

    // state == VID means a video read is returning this cycle; frame_start discards it as stale
    always_comb begin
        in_ack = state == CPU_WR || state == CPU_RD;
        occ    = cnt + CW'(state == VID);
        push   = state == VID && !frame_start;
        pop    = vid_pop && cnt != '0 && !frame_start;
        cpu_p  = run && cpu_req && !in_ack;
        vid_ok = run && !done && !frame_start && occ < CW'(FIFO_DEPTH);
        urg    = occ <= CW'(FIFO_DEPTH / 2);
        cop    = cpu_we ? CPU_WR : CPU_RD;
        op     = (cpu_p && starve == SW'(STARVE_MAX) && cnt != '0) ? cop :
                 (vid_ok && urg) ? VID : cpu_p ? cop : vid_ok ? VID : IDLE;
    end

    assign mem_en    = op != IDLE;
    assign mem_we    = op == CPU_WR;
    assign mem_addr  = op == VID ? addr : op == IDLE ? '0 : cpu_addr;
    assign mem_wdata = op == CPU_WR ? cpu_wdata : '0;
    assign cpu_ack   = in_ack;
    assign cpu_rdata = state == CPU_RD ? mem_rdata : '0;
    assign vid_pixel = pop ? fifo[rp] : '0;

    always_ff @(posedge clk)
        if (push) fifo[wp] <= mem_rdata;

    // done resets high so scan-out fetching waits for the first frame_start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run           <= 1'b0;
            done          <= 1'b1;
            addr          <= '0;
            wp            <= '0;
            rp            <= '0;
            cnt           <= '0;
            starve        <= '0;
            vid_underflow <= 1'b0;
        end else begin
            run <= 1'b1;
            if (frame_start) begin
                addr <= '0;
                done <= 1'b0;
            end else if (op == VID) begin
                if (addr == LAST) done <= 1'b1;
                else              addr <= addr + 1'b1;
            end
            if (frame_start) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= wp + PW'(push);
                rp  <= rp + PW'(pop);
                cnt <= cnt + CW'(push) - CW'(pop);
            end
            vid_underflow <= frame_start ? 1'b0 : vid_underflow | (vid_pop && cnt == '0);
            starve <= (op == CPU_WR || op == CPU_RD || in_ack) ? '0 :
                      (cpu_req && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and randomized checks of fb_arbiter against a RAM/pixel-stream model.
module tb_fb_arbiter;
    localparam int AW   = 19;
    localparam int DW   = 8;
    localparam int SMAX = 8;

    logic          clk = 1'b0, reset = 1'b1, frame_start = 1'b0, vid_pop = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] vid_pixel, cpu_rdata, mem_wdata;
    logic          vid_underflow, cpu_ack, mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    int total = 0, bad = 0, cyc = 0;
    int pix_k = 0, vexp = 0, vcnt = 0, vfirst = 0, vlast = -1, acc_cyc = -10;
    logic uf_m = 1'b0;
    logic [DW-1:0] wmem [1024];
    logic          wval [1024] = '{default: 1'b0};
    logic [DW-1:0] rd;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .vid_pop(vid_pop),
        .vid_pixel(vid_pixel), .vid_underflow(vid_underflow),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic int idx(input logic [AW-1:0] a);
        return a[18] ? 512 + int'(a[7:0]) : int'(a[8:0]);
    endfunction

    // unwritten locations read back a never-zero pattern, so a 0 pixel always means an empty pop
    function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
        return wval[idx(a)] ? wmem[idx(a)] : {a[6:0], 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {vid_pixel, vid_underflow, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] r);
        int n;
        logic [DW-1:0] e;
        e = model(a);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("cpu_ack_seen", cpu_ack, 1);
        chk("cpu_latency", n <= SMAX + 2, 1);
        chk("grant_to_ack", cyc - acc_cyc, 1);
        r = cpu_rdata;
        if (!we) chk("cpu_rdata", cpu_rdata, e);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", cpu_ack, 0);
        tick(1);
    endtask

    task automatic cpu_rand();
        cpu_op(1'($urandom_range(0, 1)), 19'h40000 + 19'($urandom_range(0, 255)), 8'($urandom), rd);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (mem_en) begin
                    if (mem_we) begin
                        wmem[idx(mem_addr)] = mem_wdata;
                        wval[idx(mem_addr)] = 1'b1;
                    end else mem_rdata <= model(mem_addr);
                end
            end
            forever begin
                @(negedge clk);
                if (!reset) begin
                    pix_k = 0; vexp = 0; vcnt = 0; uf_m = 1'b0;
                end else begin
                    chk("underflow", vid_underflow, uf_m);
                    if (cpu_ack) chk("ack_has_req", cpu_req, 1);
                    if (vid_pop && !frame_start) begin
                        if (vid_pixel == '0) uf_m = 1'b1;
                        else begin
                            chk("pixel", vid_pixel, model(AW'(pix_k)));
                            pix_k++;
                        end
                    end
                    if (mem_en) begin
                        if (mem_we) begin
                            chk("wr_req", cpu_req && cpu_we, 1);
                            chk("wr_addr", mem_addr, cpu_addr);
                            chk("wr_data", mem_wdata, cpu_wdata);
                            acc_cyc = cyc;
                        end else if (cpu_req && !cpu_we && !cpu_ack && mem_addr == cpu_addr) begin
                            acc_cyc = cyc;
                        end else begin
                            chk("vid_addr", mem_addr, vexp);
                            if (vexp == 0) vfirst = cyc;
                            vexp++; vcnt++; vlast = cyc;
                        end
                    end
                    if (frame_start) begin
                        uf_m = 1'b0; pix_k = 0; vexp = 0; vcnt = 0;
                    end
                end
            end
        join_none

        #1 reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; vid_pop = 1'b1;
        #1 chk_zero("reset_outputs");
        cpu_req = 1'b0; vid_pop = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);

        vid_pop = 1'b1;
        @(negedge clk);
        chk("empty_pixel", vid_pixel, 0);
        chk("no_fetch_before_frame", mem_en, 0);
        tick(1);
        vid_pop = 1'b0;
        tick(5);
        @(negedge clk);
        chk("uf_sticky", vid_underflow, 1);
        tick(1);

        frame_start = 1'b1;
        @(negedge clk);
        chk("fs_no_grant", mem_en, 0);
        tick(1);
        frame_start = 1'b0;
        @(negedge clk);
        chk("uf_cleared", vid_underflow, 0);
        tick(30);
        @(negedge clk);
        chk("fill_count", vcnt, 16);
        chk("fill_consecutive", vlast - vfirst, 15);
        chk("full_idle", mem_en, 0);
        tick(1);

        cpu_op(1'b1, 19'h100, 8'hA5, rd);
        cpu_op(1'b0, 19'h100, 8'h00, rd);
        chk("read_back_a5", rd, 8'hA5);

        fork
            begin
                vid_pop = 1'b1;
                tick(80);
                vid_pop = 1'b0;
            end
            repeat (6) cpu_rand();
        join
        @(negedge clk);
        chk("no_underflow_under_load", vid_underflow, 0);
        tick(1);

        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(30);
        vid_pop = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (vlast != cyc && n < 10) begin
                n++;
                @(negedge clk);
            end
        end
        chk("inflight_seen", vlast == cyc, 1);
        @(posedge clk); #1 frame_start = 1'b1;
        @(negedge clk);
        chk("fs_pop_ignored", vid_pixel, 0);
        tick(1);
        frame_start = 1'b0;
        @(negedge clk);
        chk("flushed_pop_empty", vid_pixel, 0);
        chk("restart_fetch", mem_en, 1);
        chk("restart_addr", mem_addr, 0);
        tick(1);
        vid_pop = 1'b0;
        @(negedge clk);
        chk("uf_after_flush", vid_underflow, 1);
        tick(3);
        vid_pop = 1'b1;
        tick(5);
        vid_pop = 1'b0;
        @(negedge clk);
        chk("pixels_after_flush", pix_k, 5);
        tick(1);

        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(20);
        fork
            begin
                repeat (150) begin
                    vid_pop = 1'($urandom_range(0, 1));
                    tick(1);
                end
                vid_pop = 1'b0;
            end
            repeat (10) begin
                tick($urandom_range(1, 4));
                cpu_rand();
            end
        join
        tick(2);

        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(5);
        @(negedge clk);
        chk("pre_reset_fetch", mem_en, 1);
        #2 reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; vid_pop = 1'b1;
        #1 chk_zero("async_reset_outputs");
        cpu_req = 1'b0; vid_pop = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(3);
        @(negedge clk);
        chk("idle_after_reset", mem_en, 0);
        tick(1);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        @(negedge clk);
        chk("restart_after_reset_en", mem_en, 1);
        chk("restart_after_reset_addr", mem_addr, 0);
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
